// File: rtl/sigmoid_pkg.sv
// Shared constants, chord tables and pipeline stage types for the sigmoid block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sigmoid_pkg;

   localparam int FRAC_W = 16;
   localparam int N_SEG  = 16;

   localparam logic [31:0] SAT_LIMIT = 32'h0008_0000;   // |x| >= 8.0
   localparam logic [16:0] ONE_Q16   = 17'h1_0000;      // 1.0 in Q0.16 with headroom bit

   typedef logic signed [31:0] q16_16_t;

   // Chord endpoints: SIG_B[i] = sigmoid(i*0.5), rounded to nearest, Q0.16.
   localparam logic [16:0] SIG_B [N_SEG] = '{
      17'h0_8000, 17'h0_9F59, 17'h0_BB27, 17'h0_D14D,
      17'h0_E17C, 17'h0_EC95, 17'h0_F3DC, 17'h0_F87F,
      17'h0_FB65, 17'h0_FD30, 17'h0_FE49, 17'h0_FEF5,
      17'h0_FF5E, 17'h0_FF9E, 17'h0_FFC4, 17'h0_FFDC
   };

   // Chord slopes: (sigmoid((i+1)*0.5) - sigmoid(i*0.5)) / 0.5, rounded, Q0.16.
   localparam logic [15:0] SIG_M [N_SEG] = '{
      16'h3EB3, 16'h379A, 16'h2C4C, 16'h205F,
      16'h1631, 16'h0E8F, 16'h0946, 16'h05CD,
      16'h0395, 16'h0233, 16'h0158, 16'h00D1,
      16'h007F, 16'h004D, 16'h002F, 16'h001C
   };

   // Stage 1: sign, saturation flag and the magnitude bits below 8.0.
   typedef struct packed {
      logic        sign;
      logic        sat;
      logic [18:0] mag;
   } s1_t;

   // Stage 2: segment coefficients plus offset inside the segment.
   typedef struct packed {
      logic        sign;
      logic        sat;
      logic [14:0] off;
      logic [16:0] b;
      logic [15:0] m;
   } s2_t;

   // Stage 3: interpolated sigmoid of |x|.
   typedef struct packed {
      logic        sign;
      logic [16:0] p;
   } s3_t;

endpackage

// File: rtl/sigmoid_seg_rom.sv
// Segment coefficient lookup: idx_i -> chord base b_o and slope m_o.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of idx_i.
// Ports: idx_i segment index (|x| / 0.5), b_o Q0.16 base (17b), m_o Q0.16 slope (16b).
module sigmoid_seg_rom
   import sigmoid_pkg::*;
(
   input  logic [3:0]  idx_i,
   output logic [16:0] b_o,
   output logic [15:0] m_o
);

   always_comb begin
      b_o = SIG_B[idx_i];
      m_o = SIG_M[idx_i];
   end

endmodule

// File: rtl/sigmoid.sv
// Pipelined Q16.16 logistic function via 16-segment chord interpolation on |x| < 8.
// Latency: 4 enabled cycles, one sample per cycle.
// Backpressure: none; en=0 freezes every stage and data_out.
// Ports: clk, rst (sync, active-low), en (global stall), data_in (signed Q16.16 x),
//        data_out (Q16.16 y in 0x00000000..0x00010000).
module sigmoid
   import sigmoid_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int FRAC_W = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out
);

   s1_t         s1_d, s1_q;
   s2_t         s2_d, s2_q;
   s3_t         s3_d, s3_q;
   logic [16:0] y_d,  y_q;

   logic [DATA_W-1:0] abs_x;
   logic [16:0]       rom_b;
   logic [15:0]       rom_m;
   logic [14:0]       slope_term;

   // Stage 1: magnitude is unsigned so 0x80000000 becomes 2^31 and saturates.
   always_comb begin
      abs_x    = data_in[DATA_W-1] ? ((~data_in) + DATA_W'(1)) : data_in;
      s1_d      = '0;
      s1_d.sign = data_in[DATA_W-1];
      s1_d.sat  = (abs_x >= SAT_LIMIT);
      s1_d.mag  = abs_x[FRAC_W+2:0];
   end

   // Stage 2: the 0.5-wide segment index sits just above the 15 offset bits.
   sigmoid_seg_rom u_seg_rom (
      .idx_i (s1_q.mag[FRAC_W+2:FRAC_W-1]),
      .b_o   (rom_b),
      .m_o   (rom_m)
   );

   always_comb begin
      s2_d      = '0;
      s2_d.sign = s1_q.sign;
      s2_d.sat  = s1_q.sat;
      s2_d.off  = s1_q.mag[FRAC_W-2:0];
      s2_d.b    = rom_b;
      s2_d.m    = rom_m;
   end

   // Stage 3: slope*off < 0.245*0.5 in Q0.16, so it fits 15 bits after the shift,
   // and the table keeps every segment end at or below the next base.
   always_comb begin
      slope_term = 15'(({16'b0, s2_q.m} * {17'b0, s2_q.off}) >> FRAC_W);
      s3_d       = '0;
      s3_d.sign  = s2_q.sign;
      s3_d.p     = s2_q.sat ? ONE_Q16 : (s2_q.b + {2'b0, slope_term});
   end

   // Stage 4: fold negative inputs using sigmoid(-x) = 1 - sigmoid(x).
   always_comb begin
      y_d = s3_q.sign ? (ONE_Q16 - s3_q.p) : s3_q.p;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
         y_q  <= '0;
      end else if (en) begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
         y_q  <= y_d;
      end
   end

   assign data_out = {{(DATA_W-FRAC_W-1){1'b0}}, y_q};

endmodule

// File: tb/tb_sigmoid.sv
// Directed and streamed checks of the sigmoid pipeline against hand values and exp().
// Latency: outputs checked 4 enabled cycles after their input is sampled.
// Backpressure: exercises en stalls mid-stream.
module tb_sigmoid;

   logic        clk;
   logic        rst;
   logic        en;
   logic [31:0] data_in;
   logic [31:0] data_out;

   int n_tests = 0;
   int n_fail  = 0;

   // Bench-side history of inputs still in flight (index 3 is the one on data_out).
   logic [31:0] hx [4];
   logic        hv [4];
   bit          mono_mode = 0;
   bit          mono_have = 0;
   logic [31:0] mono_prev = '0;

   localparam int TOL = 262;

   sigmoid #(.DATA_W(32), .FRAC_W(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .data_in  (data_in),
      .data_out (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp, input int tol);
      longint d;
      n_tests++;
      d = longint'(got) - longint'(exp);
      if (d < 0) d = -d;
      if (d > longint'(tol)) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (tol %0d)", tag, got, exp, tol);
      end
   endtask

   function automatic logic [31:0] ref_q(input logic [31:0] x);
      int  xi;
      real xr, yr;
      xi = int'($signed(x));
      xr = real'(xi) / 65536.0;
      yr = 65536.0 / (1.0 + $exp(-xr));
      return 32'(int'($floor(yr + 0.5)));
   endfunction

   // Hold x for 4 enabled cycles and leave the matching output on data_out.
   task automatic apply(input logic [31:0] x);
      @(negedge clk);
      en      = 1'b1;
      data_in = x;
      repeat (4) @(posedge clk);
      #1;
   endtask

   // One streaming cycle: check what the pipeline presents, then feed x.
   task automatic push(input logic [31:0] x, input logic v);
      @(negedge clk);
      if (hv[3]) begin
         check("stream", data_out, ref_q(hx[3]), TOL);
         check("upper", {17'b0, data_out[31:17]}, 32'd0, 0);
         if (mono_mode) begin
            if (mono_have) check("mono", {31'b0, data_out >= mono_prev}, 32'd1, 0);
            mono_prev = data_out;
            mono_have = 1'b1;
         end
      end
      en      = 1'b1;
      data_in = x;
      @(posedge clk);
      hx[3] = hx[2]; hv[3] = hv[2];
      hx[2] = hx[1]; hv[2] = hv[1];
      hx[1] = hx[0]; hv[1] = hv[0];
      hx[0] = x;     hv[0] = v;
   endtask

   task automatic flush();
      for (int k = 0; k < 4; k++) push(32'h0, 1'b0);
   endtask

   task automatic stall3();
      logic [31:0] held;
      @(negedge clk);
      held = data_out;
      en   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         data_in = $urandom;
         @(posedge clk);
         #1;
         check("stall", data_out, held, 0);
      end
   endtask

   function automatic logic [31:0] narrow_rand();
      int v;
      v = int'($urandom_range(32'h0012_0000, 0)) - 32'sh0009_0000;
      return 32'(v);
   endfunction

   initial begin
      logic [31:0] yp, ym;
      int          xs;

      for (int k = 0; k < 4; k++) begin hx[k] = '0; hv[k] = 1'b0; end
      rst     = 1'b0;
      en      = 1'b0;
      data_in = '0;

      // Reset state
      repeat (5) @(posedge clk);
      #1;
      check("reset", data_out, 32'h0, 0);
      @(negedge clk);
      rst = 1'b1;

      // Centre point and breakpoints
      apply(32'h0000_0000); check("x_zero",   data_out, 32'h0000_8000, 0);
      apply(32'h0001_0000); check("bp_p1",    data_out, 32'h0000_BB27, 2); yp = data_out;
      apply(32'hFFFF_0000); check("bp_m1",    data_out, 32'h0000_44D9, 2); ym = data_out;
      check("bp_sum", yp + ym, 32'h0001_0000, 0);

      // Saturation on both sides
      apply(32'h0008_0000); check("sat_p8",   data_out, 32'h0001_0000, 0);
      apply(32'h7FFF_FFFF); check("sat_pmax", data_out, 32'h0001_0000, 0);
      apply(32'hFFF8_0000); check("sat_m8",   data_out, 32'h0000_0000, 0);
      apply(32'h8000_0000); check("sat_mmin", data_out, 32'h0000_0000, 0);

      // Interior accuracy
      apply(32'h0002_4000); check("x_2p25",   data_out, 32'h0000_E797, TOL);
      apply(32'hFFFD_C000); check("x_m2p25",  data_out, 32'h0000_1869, TOL);

      // Ten streamed samples with a 3-cycle stall in the middle
      for (int i = 0; i < 10; i++) begin
         if (i == 5) stall3();
         push(narrow_rand(), 1'b1);
      end
      flush();

      // Reset mid-stream drops everything in flight
      for (int i = 0; i < 3; i++) push(narrow_rand(), 1'b1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_mid", data_out, 32'h0, 0);
      for (int k = 0; k < 4; k++) hv[k] = 1'b0;
      @(negedge clk);
      rst     = 1'b1;
      en      = 1'b1;
      data_in = 32'h0001_0000;
      @(posedge clk);
      #1;
      check("rst_drop", data_out, 32'h0, 0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_resume", data_out, 32'h0000_BB27, 2);

      // Random sweep: full-range and near-range inputs
      for (int i = 0; i < 5000; i++) push($urandom, 1'b1);
      for (int i = 0; i < 5000; i++) push(narrow_rand(), 1'b1);
      flush();

      // Sorted sweep from about -9.0 to +9.3 for monotonicity
      mono_mode = 1'b1;
      xs = -32'sh0009_0000;
      for (int i = 0; i < 4000; i++) begin
         push(32'(xs), 1'b1);
         xs = xs + 300;
      end
      flush();
      mono_mode = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
